// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit-path sequencer.
// Holds the FSM state and owner encodings, the EOP bit counts and the output bundle.
package usb_tx_pkg;

  localparam int unsigned CNT_W        = 8;
  localparam int unsigned EOP_SE0_BITS = 2;
  localparam int unsigned EOP_J_BITS   = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_SENDING = 3'd2,
    ST_EOP_SE0 = 3'd3,
    ST_EOP_J   = 3'd4,
    ST_GAP     = 3'd5
  } txseq_state_t;

  typedef enum logic {
    OWN_TOKEN = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  // Registered output bundle driven by the sequencer.
  typedef struct packed {
    logic tok_gnt;
    logic data_gnt;
    logic eop_se0;
    logic eop_j;
    logic tx_busy;
    logic tx_done;
    logic start_err;
  } txseq_out_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_TOKEN) ? OWN_DATA : OWN_TOKEN;
  endfunction

endpackage

// File: rtl/tx_rr_pick.sv
// Round-robin pick between the token and data encoder requests.
// On a tie the path that did not win last time is chosen.
module tx_rr_pick
  import usb_tx_pkg::*;
(
  input  logic   tok_req,
  input  logic   data_req,
  input  owner_t last_owner,
  output logic   pick_valid,
  output owner_t pick_owner
);

  always_comb begin
    pick_valid = tok_req | data_req;
    pick_owner = OWN_TOKEN;
    if (tok_req && data_req) begin
      pick_owner = other_owner(last_owner);
    end else if (data_req) begin
      pick_owner = OWN_DATA;
    end
  end

endmodule

// File: rtl/tx_path_sequencer.sv
// Transmit-path sequencer: grants the bit stuffer to one encoder, then drives
// the EOP (SE0, SE0, J) and an idle gap before the next grant.
module tx_path_sequencer
  import usb_tx_pkg::*;
#(
  parameter int unsigned GAP_CYCLES    = 2,
  parameter int unsigned START_TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic tok_req,
  input  logic data_req,
  input  logic bs_sending,
  output logic tok_gnt,
  output logic data_gnt,
  output logic eop_se0,
  output logic eop_j,
  output logic tx_busy,
  output logic tx_done,
  output logic start_err
);

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SE0_LAST = CNT_W'(EOP_SE0_BITS - 1);
  localparam logic [CNT_W-1:0] J_LAST   = CNT_W'(EOP_J_BITS - 1);

  txseq_state_t     state,      state_nxt;
  owner_t           owner,      owner_nxt;
  owner_t           last_owner, last_owner_nxt;
  logic [CNT_W-1:0] to_cnt,     to_cnt_nxt;
  logic [CNT_W-1:0] gap_cnt,    gap_cnt_nxt;
  logic [CNT_W-1:0] eop_cnt,    eop_cnt_nxt;
  txseq_out_t       out_q,      out_nxt;
  logic             timeout_hit;
  logic             entering;
  logic             pick_valid;
  owner_t           pick_owner;

  tx_rr_pick u_rr_pick (
    .tok_req    (tok_req),
    .data_req   (data_req),
    .last_owner (last_owner),
    .pick_valid (pick_valid),
    .pick_owner (pick_owner)
  );

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    timeout_hit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_nxt      = ST_ARMED;
          owner_nxt      = pick_owner;
          last_owner_nxt = pick_owner;
        end
      end
      ST_ARMED: begin
        if (bs_sending) begin
          state_nxt = ST_SENDING;
        end else if (to_cnt == TO_LAST) begin
          state_nxt   = ST_IDLE;
          timeout_hit = 1'b1;
        end
      end
      ST_SENDING: begin
        if (!bs_sending) begin
          state_nxt = ST_EOP_SE0;
        end
      end
      ST_EOP_SE0: begin
        if (eop_cnt == SE0_LAST) begin
          state_nxt = ST_EOP_J;
        end
      end
      ST_EOP_J: begin
        if (eop_cnt == J_LAST) begin
          state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Counters clear on every state change and only advance in their own state.
  always_comb begin
    entering    = (state_nxt != state);
    to_cnt_nxt  = to_cnt;
    gap_cnt_nxt = gap_cnt;
    eop_cnt_nxt = eop_cnt;
    if (entering) begin
      to_cnt_nxt  = '0;
      gap_cnt_nxt = '0;
      eop_cnt_nxt = '0;
    end else begin
      if (state == ST_ARMED) begin
        to_cnt_nxt = to_cnt + CNT_W'(1);
      end
      if (state == ST_GAP) begin
        gap_cnt_nxt = gap_cnt + CNT_W'(1);
      end
      if ((state == ST_EOP_SE0) || (state == ST_EOP_J)) begin
        eop_cnt_nxt = eop_cnt + CNT_W'(1);
      end
    end
  end

  // Outputs are computed from the upcoming state so they register alongside it.
  always_comb begin
    out_nxt           = '0;
    out_nxt.tok_gnt   = ((state_nxt == ST_ARMED) || (state_nxt == ST_SENDING)) &&
                        (owner_nxt == OWN_TOKEN);
    out_nxt.data_gnt  = ((state_nxt == ST_ARMED) || (state_nxt == ST_SENDING)) &&
                        (owner_nxt == OWN_DATA);
    out_nxt.eop_se0   = (state_nxt == ST_EOP_SE0);
    out_nxt.eop_j     = (state_nxt == ST_EOP_J);
    out_nxt.tx_busy   = (state_nxt != ST_IDLE);
    out_nxt.tx_done   = ((state_nxt == ST_EOP_J) && (GAP_CYCLES == 0)) ||
                        ((state_nxt == ST_GAP) && (gap_cnt_nxt == GAP_LAST));
    out_nxt.start_err = timeout_hit;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      owner      <= OWN_TOKEN;
      last_owner <= OWN_DATA;
      to_cnt     <= '0;
      gap_cnt    <= '0;
      eop_cnt    <= '0;
      out_q      <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      to_cnt     <= to_cnt_nxt;
      gap_cnt    <= gap_cnt_nxt;
      eop_cnt    <= eop_cnt_nxt;
      out_q      <= out_nxt;
    end
  end

  assign tok_gnt   = out_q.tok_gnt;
  assign data_gnt  = out_q.data_gnt;
  assign eop_se0   = out_q.eop_se0;
  assign eop_j     = out_q.eop_j;
  assign tx_busy   = out_q.tx_busy;
  assign tx_done   = out_q.tx_done;
  assign start_err = out_q.start_err;

  grant_exclusive : assert property (@(posedge clock) disable iff (!reset_n)
                                     !(tok_gnt && data_gnt));

endmodule

// File: tb/tb_tx_path_sequencer.sv
// Bench for tx_path_sequencer: builds expected per-cycle waveforms from packet
// timing rules and compares two instances (gap of 2 and gap of 0).
module tb_tx_path_sequencer;

  localparam int TO     = 16;
  localparam int MAXC   = 1024;
  localparam int B_TOK  = 6;
  localparam int B_DAT  = 5;
  localparam int B_SE0  = 4;
  localparam int B_J    = 3;
  localparam int B_BUSY = 2;
  localparam int B_DONE = 1;
  localparam int B_ERR  = 0;

  logic clock;
  logic reset_n;
  logic tok_req;
  logic data_req;
  logic bs_sending;

  logic a_tok_gnt, a_data_gnt, a_eop_se0, a_eop_j, a_tx_busy, a_tx_done, a_start_err;
  logic b_tok_gnt, b_data_gnt, b_eop_se0, b_eop_j, b_tx_busy, b_tx_done, b_start_err;
  logic [6:0] obs_a;
  logic [6:0] obs_b;

  int total;
  int bad;

  logic [6:0] exp_q [MAXC];
  bit         bs_q  [MAXC];
  bit         pk_to [8];
  int         pk_d  [8];
  int         pk_l  [8];

  tx_path_sequencer #(.GAP_CYCLES(2), .START_TIMEOUT(TO)) u_dut_a (
    .clock      (clock),
    .reset_n    (reset_n),
    .tok_req    (tok_req),
    .data_req   (data_req),
    .bs_sending (bs_sending),
    .tok_gnt    (a_tok_gnt),
    .data_gnt   (a_data_gnt),
    .eop_se0    (a_eop_se0),
    .eop_j      (a_eop_j),
    .tx_busy    (a_tx_busy),
    .tx_done    (a_tx_done),
    .start_err  (a_start_err)
  );

  tx_path_sequencer #(.GAP_CYCLES(0), .START_TIMEOUT(TO)) u_dut_b (
    .clock      (clock),
    .reset_n    (reset_n),
    .tok_req    (tok_req),
    .data_req   (data_req),
    .bs_sending (bs_sending),
    .tok_gnt    (b_tok_gnt),
    .data_gnt   (b_data_gnt),
    .eop_se0    (b_eop_se0),
    .eop_j      (b_eop_j),
    .tx_busy    (b_tx_busy),
    .tx_done    (b_tx_done),
    .start_err  (b_start_err)
  );

  assign obs_a = {a_tok_gnt, a_data_gnt, a_eop_se0, a_eop_j, a_tx_busy, a_tx_done, a_start_err};
  assign obs_b = {b_tok_gnt, b_data_gnt, b_eop_se0, b_eop_j, b_tx_busy, b_tx_done, b_start_err};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic do_reset();
    reset_n    = 1'b0;
    tok_req    = 1'b0;
    data_req   = 1'b0;
    bs_sending = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic set_pk(input int i, input bit to, input int d, input int l);
    pk_to[i] = to;
    pk_d[i]  = d;
    pk_l[i]  = l;
  endtask

  // Expected waveform from packet rules: grant d+L+1 cycles (or TO on timeout),
  // then SE0 x2, J, gap cycles with done on the last, one IDLE, next grant.
  task automatic build(input int gap, input bit tok, input bit dat, input int npk,
                       output int drop_c, output int ncyc);
    int t;
    int glen;
    int g;
    bit own;
    bit last;
    for (int c = 0; c < MAXC; c++) begin
      exp_q[c] = '0;
      bs_q[c]  = 1'b0;
    end
    t      = 0;
    last   = 1'b1;
    drop_c = 0;
    for (int i = 0; i < npk; i++) begin
      own  = (tok && dat) ? ~last : dat;
      last = own;
      g    = own ? B_DAT : B_TOK;
      if (pk_to[i]) begin
        for (int k = 0; k < TO; k++) begin
          exp_q[t+k][g]      = 1'b1;
          exp_q[t+k][B_BUSY] = 1'b1;
        end
        exp_q[t+TO][B_ERR] = 1'b1;
        bs_q[t+TO]         = 1'($urandom_range(0, 1));
        drop_c             = t + TO;
        t                  = t + TO + 1;
      end else begin
        glen = pk_d[i] + pk_l[i] + 1;
        for (int k = 0; k < glen; k++) begin
          exp_q[t+k][g]      = 1'b1;
          exp_q[t+k][B_BUSY] = 1'b1;
        end
        for (int k = 0; k < pk_l[i]; k++) bs_q[t+pk_d[i]+k] = 1'b1;
        exp_q[t+glen][B_SE0]   = 1'b1;
        exp_q[t+glen+1][B_SE0] = 1'b1;
        exp_q[t+glen+2][B_J]   = 1'b1;
        for (int k = 0; k < 3 + gap; k++) exp_q[t+glen+k][B_BUSY] = 1'b1;
        exp_q[t+glen+2+gap][B_DONE] = 1'b1;
        for (int k = 0; k < 4 + gap; k++) bs_q[t+glen+k] = 1'($urandom_range(0, 1));
        drop_c = t + glen + 2 + gap;
        t      = t + glen + 4 + gap;
      end
    end
    ncyc = drop_c + 4;
  endtask

  task automatic run_seq(input bit sel, input bit tok, input bit dat, input int npk,
                         input string name);
    int drop_c;
    int ncyc;
    logic [6:0] o;
    do_reset();
    build(sel ? 0 : 2, tok, dat, npk, drop_c, ncyc);
    tok_req  = tok;
    data_req = dat;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clock);
      #1;
      o = sel ? obs_b : obs_a;
      total++;
      if (o !== exp_q[c]) begin
        bad++;
        $display("FAIL %s cycle %0d: got %b want %b", name, c, o, exp_q[c]);
      end
      total++;
      if (o[B_TOK] && o[B_DAT]) begin
        bad++;
        $display("FAIL %s exclusive cycle %0d: got both grants, want at most one", name, c);
      end
      bs_sending = bs_q[c];
      if (c == drop_c) begin
        tok_req  = 1'b0;
        data_req = 1'b0;
      end
    end
    bs_sending = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tok_req = 1'b0;
    data_req = 1'b0;
    bs_sending = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (obs_a !== 7'b0) begin
      bad++;
      $display("FAIL reset_a: got %b want 0000000", obs_a);
    end
    total++;
    if (obs_b !== 7'b0) begin
      bad++;
      $display("FAIL reset_b: got %b want 0000000", obs_b);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single_token();
    set_pk(0, 1'b0, 2, 20);
    run_seq(1'b0, 1'b1, 1'b0, 1, "single_token");
  endtask

  task automatic test_tie_fairness();
    for (int i = 0; i < 4; i++) set_pk(i, 1'b0, $urandom_range(0, TO - 1), $urandom_range(1, 10));
    run_seq(1'b0, 1'b1, 1'b1, 4, "tie_fairness");
  endtask

  task automatic test_start_timeout();
    set_pk(0, 1'b1, 0, 0);
    run_seq(1'b0, 1'b0, 1'b1, 1, "start_timeout");
  endtask

  task automatic test_timeout_race();
    set_pk(0, 1'b0, TO - 1, $urandom_range(1, 8));
    run_seq(1'b0, 1'b0, 1'b1, 1, "timeout_race");
  endtask

  task automatic test_gap_zero();
    set_pk(0, 1'b0, $urandom_range(0, 4), $urandom_range(1, 8));
    set_pk(1, 1'b0, $urandom_range(0, 4), $urandom_range(1, 8));
    run_seq(1'b1, 1'b1, 1'b0, 2, "gap_zero");
  endtask

  task automatic test_random_mix();
    int npk;
    int rq;
    bit sel;
    for (int r = 0; r < 6; r++) begin
      npk = $urandom_range(1, 4);
      rq  = $urandom_range(1, 3);
      sel = 1'($urandom_range(0, 1));
      for (int i = 0; i < npk; i++) begin
        set_pk(i, ($urandom_range(0, 3) == 0), $urandom_range(0, TO - 1), $urandom_range(1, 12));
      end
      run_seq(sel, rq[0], rq[1], npk, "random_mix");
    end
  endtask

  task automatic test_reset_mid_eop();
    do_reset();
    tok_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock);
      #1;
      bs_sending = (c < 3);
    end
    tok_req = 1'b0;
    @(posedge clock);
    #1;
    total++;
    if (obs_a !== 7'b0010100) begin
      bad++;
      $display("FAIL mid_eop_se0: got %b want 0010100", obs_a);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (obs_a !== 7'b0) begin
      bad++;
      $display("FAIL mid_eop_async_a: got %b want 0000000", obs_a);
    end
    total++;
    if (obs_b !== 7'b0) begin
      bad++;
      $display("FAIL mid_eop_async_b: got %b want 0000000", obs_b);
    end
    tok_req  = 1'b1;
    data_req = 1'b1;
    #3;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    total++;
    if (obs_a !== 7'b1000100) begin
      bad++;
      $display("FAIL mid_eop_tie_token: got %b want 1000100", obs_a);
    end
    tok_req  = 1'b0;
    data_req = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_token();
    test_tie_fairness();
    test_start_timeout();
    test_timeout_race();
    test_gap_zero();
    test_random_mix();
    test_reset_mid_eop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_path_sequencer.md
# tx_path_sequencer

Transmit-path sequencer for the USB controller. It arbitrates between the token encoder (CRC5 path) and the data encoder (CRC16 path) for exclusive use of the shared bit stuffer. It watches the stuffer's `bs_sending` to detect packet end, then generates the EOP (SE0, SE0, J) and enforces an inter-packet idle gap before granting again. It sits between the two packet encoders and the bit stuffer / NRZI output stage.

## Interface
Parameters:
- `GAP_CYCLES`, default 2: idle bit-times after EOP before the next grant; legal range 0..255.
- `START_TIMEOUT`, default 16: maximum cycles a grant may wait for `bs_sending` to rise; legal range 1..255.

Ports (one clock; reset is asynchronous and active-low):
- `clock`  in  1: bit-rate clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `tok_req`  in  1: token encoder requests the stuffer; level, held until `tx_done` or `start_err`.
- `data_req`  in  1: data encoder requests the stuffer; level, same rule.
- `bs_sending`  in  1: bit stuffer is emitting packet bits.
- `tok_gnt`  out  1: token path owns the stuffer.
- `data_gnt`  out  1: data path owns the stuffer.
- `eop_se0`  out  1: drive SE0 on the line.
- `eop_j`  out  1: drive J on the line.
- `tx_busy`  out  1: high in every state except IDLE.
- `tx_done`  out  1: one-cycle pulse when the sequence completes.
- `start_err`  out  1: one-cycle pulse when a grant times out.

## Operation
- Moore FSM with states IDLE, ARMED, SENDING, EOP_SE0, EOP_J, GAP. All outputs are decoded from registered state and flags, and all are 0 at reset.
- **IDLE**
  - If either request is high, load `owner` and go to ARMED.
  - If both are high, use round-robin: the winner is the path that did not win last. `last_owner` resets to DATA, so the first tie goes to TOKEN.
- **ARMED**
  - The owner's grant is high.
  - `to_cnt` increments each cycle.
  - If `bs_sending` is 1, go to SENDING.
  - Otherwise, if `to_cnt` equals `START_TIMEOUT`-1, go to IDLE and pulse `start_err` in the next cycle. `last_owner` still updates.
- **SENDING**
  - The grant is held.
  - On the first cycle `bs_sending` is sampled 0, go to EOP_SE0.
- **EOP_SE0**
  - Grants are 0 and `eop_se0` is 1.
  - Lasts exactly 2 cycles, counted by `eop_cnt`, then go to EOP_J.
- **EOP_J**
  - `eop_j` is 1 for 1 cycle.
  - If `GAP_CYCLES` is 0, go to IDLE; otherwise go to GAP.
- **GAP**
  - All line outputs are 0.
  - Lasts `GAP_CYCLES` cycles, then go to IDLE.
- **`tx_done`** is high during the final cycle of the sequence: the last GAP cycle, or EOP_J when `GAP_CYCLES` is 0.
- **Counters:** `to_cnt`, `gap_cnt` and `eop_cnt` are 8-bit and cleared on every state entry. They never wrap, because exit occurs at terminal count.
- **Request sampling:** requests are sampled only in IDLE. A request that is still high in IDLE after `tx_done` is treated as a new request.
- **`bs_sending` in other states:** ignored in IDLE, EOP and GAP, including a spurious high.
- **Invariant:** `tok_gnt` and `data_gnt` are never high together.
- **Reset mid-operation:** the state goes to IDLE immediately, asynchronously, and all outputs drop. `last_owner` returns to DATA.

## Timing
- Request sampled high at edge t: grant is high from cycle t+1.
- `bs_sending` sampled 0 at edge s: grant is low and `eop_se0` is high from cycle s+1.
  - Cycles s+1 and s+2: SE0.
  - Cycle s+3: J.
  - Cycles s+4 to s+3+`GAP_CYCLES`: GAP.
  - `tx_done` is high in cycle s+3+`GAP_CYCLES`.
  - Earliest next grant is cycle s+5+`GAP_CYCLES` (IDLE occupies one cycle).
- Timeout: the grant lasts exactly `START_TIMEOUT` cycles. `start_err` is high in the first IDLE cycle after ARMED.
- If `bs_sending` rises on the same edge the timeout terminal count is reached, `bs_sending` wins and the FSM goes to SENDING.

## Structure
- `usb_tx_pkg` holds:
  - the state enum `txseq_state_t`;
  - the owner enum `{OWN_TOKEN, OWN_DATA}`;
  - constant `EOP_SE0_BITS = 2`;
  - constant `EOP_J_BITS = 1`.
- Sub-module `tx_rr_pick` (combinational): inputs are `tok_req`, `data_req` and `last_owner`; outputs are `pick_valid` and `pick_owner`. The FSM, the counters and `last_owner` live in `tx_path_sequencer`.

## Test plan
- **Single token:** raise `tok_req`; `bs_sending` high for 20 cycles starting 3 cycles after grant. Expect `tok_gnt` for 23 cycles, then SE0 for 2 cycles, J for 1, GAP for 2; `tx_done` on the 5th post-packet cycle; `data_gnt` stays 0.
- **Tie and fairness:** hold both requests high from reset. Expect grant order TOKEN, DATA, TOKEN, DATA across four packets, with no cycle where both grants are high.
- **Start timeout:** `data_req` high and `bs_sending` held 0. Expect `data_gnt` for exactly 16 cycles, a `start_err` pulse in the next cycle, and no EOP.
- **Timeout race:** `bs_sending` rises on the 16th ARMED cycle. Expect SENDING, no `start_err`, and a normal EOP.
- **GAP_CYCLES=0:** run one packet. Expect `tx_done` in the J cycle; a held request is granted 2 cycles after J.
- **Reset mid-EOP:** assert `reset_n` low during the first SE0 cycle. Expect all outputs 0 without waiting for a clock edge; after release, a tie grants TOKEN first.
